// File: rtl/acc_cpu_pkg.sv
// Shared opcode and state encodings for the accumulator CPU.
// An execute-state code is the 3-bit opcode with bit 3 set, which is why DECODE needs no lookup.
package acc_cpu_pkg;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_INPUT = 3'd4;
    localparam logic [2:0] OP_JZ    = 3'd5;
    localparam logic [2:0] OP_JPOS  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_INPUT  = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    function automatic state_t exec_state(input logic [2:0] op);
        return state_t'({1'b1, op});
    endfunction

endpackage

// File: rtl/acc_cpu_core_if.sv
// Board-side signal bundle of the accumulator CPU: operator controls, program-load port, status.
interface acc_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              run;
    logic              enter;
    logic [DATA_W-1:0] nin;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] nout;
    logic              out_stb;
    logic              wait_in;
    logic              halt;
    logic              ovf;
    logic [2:0]        ir_op;
    logic [ADDR_W-1:0] pc_out;
    logic [3:0]        state_no;

    modport master (
        output run, enter, nin, prog_we, prog_addr, prog_data,
        input  nout, out_stb, wait_in, halt, ovf, ir_op, pc_out, state_no
    );

    modport slave (
        input  run, enter, nin, prog_we, prog_addr, prog_data,
        output nout, out_stb, wait_in, halt, ovf, ir_op, pc_out, state_no
    );
endinterface

// File: rtl/acc_cpu_core_tick_gen.sv
// Clock-enable generator: one-clock tick every CLK_DIV clocks.
// With CLK_DIV=1 the counter is pinned at its terminal count, so tick is constantly high.
module tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (cnt_reg == TERM) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tick = (cnt_reg == TERM);
endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator processor: control FSM, datapath (A, PC, IR, ALU) and program RAM.
// The FSM advances only on tick; the enter synchroniser and RAM loading run on every clock.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int CLK_DIV = 1
) (
    input  logic            clock,
    input  logic            reset,
    acc_cpu_core_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int MSB   = DATA_W - 1;

    state_t            state_reg;
    logic [DATA_W-1:0] a_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [2:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              ovf_reg;
    logic              out_stb_reg;
    logic              sync1_reg, sync2_reg, edge_prev_reg, enter_seen_reg;
    logic              tick;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;
    logic              prog_window;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] sum, diff;
    logic              add_ovf, sub_ovf;
    logic              aeq0, apos;
    logic              enter_rise;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // One read port: FETCH reads at PC, every other state reads the operand at IR's address.
    assign rd_addr = (state_reg == S_FETCH) ? pc_reg : addr_reg;
    assign rd_data = mem[rd_addr];

    assign sum     = a_reg + rd_data;
    assign diff    = a_reg - rd_data;
    assign add_ovf = (a_reg[MSB] == rd_data[MSB]) && (sum[MSB]  != a_reg[MSB]);
    assign sub_ovf = (a_reg[MSB] != rd_data[MSB]) && (diff[MSB] != a_reg[MSB]);
    assign aeq0    = (a_reg == '0);
    assign apos    = !a_reg[MSB] && !aeq0;

    // The loader only owns the RAM while the core is idle, so it can never collide with STORE.
    assign prog_window = (state_reg == S_START) || (state_reg == S_HALT);
    assign mem_we      = (bus.prog_we && prog_window) || (tick && state_reg == S_STORE);
    assign wr_addr     = prog_window ? bus.prog_addr : addr_reg;
    assign wr_data     = prog_window ? bus.prog_data : a_reg;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            edge_prev_reg <= 1'b0;
        end else begin
            sync1_reg     <= bus.enter;
            sync2_reg     <= sync1_reg;
            edge_prev_reg <= sync2_reg;
        end
    end

    assign enter_rise = sync2_reg && !edge_prev_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_START;
            a_reg          <= '0;
            pc_reg         <= '0;
            op_reg         <= '0;
            addr_reg       <= '0;
            ovf_reg        <= 1'b0;
            out_stb_reg    <= 1'b0;
            enter_seen_reg <= 1'b0;
        end else begin
            out_stb_reg <= 1'b0;
            // Edges are latched every clock so one arriving between ticks is not lost.
            if (enter_rise) begin
                enter_seen_reg <= 1'b1;
            end
            if (tick) begin
                case (state_reg)
                    S_START: begin
                        if (bus.run) state_reg <= S_FETCH;
                    end
                    S_FETCH: begin
                        op_reg    <= rd_data[MSB -: 3];
                        addr_reg  <= rd_data[ADDR_W-1:0];
                        pc_reg    <= pc_reg + ADDR_W'(1);
                        state_reg <= S_DECODE;
                    end
                    S_DECODE: begin
                        // Stale presses from before this INPUT are discarded here.
                        if (op_reg == OP_INPUT) enter_seen_reg <= 1'b0;
                        state_reg <= exec_state(op_reg);
                    end
                    S_LOAD: begin
                        a_reg       <= rd_data;
                        out_stb_reg <= 1'b1;
                        state_reg   <= S_FETCH;
                    end
                    S_STORE: begin
                        state_reg <= S_FETCH;
                    end
                    S_ADD: begin
                        a_reg       <= sum;
                        ovf_reg     <= add_ovf;
                        out_stb_reg <= 1'b1;
                        state_reg   <= S_FETCH;
                    end
                    S_SUB: begin
                        a_reg       <= diff;
                        ovf_reg     <= sub_ovf;
                        out_stb_reg <= 1'b1;
                        state_reg   <= S_FETCH;
                    end
                    S_INPUT: begin
                        if (enter_seen_reg) begin
                            a_reg       <= bus.nin;
                            out_stb_reg <= 1'b1;
                            state_reg   <= S_FETCH;
                        end
                    end
                    S_JZ: begin
                        if (aeq0) pc_reg <= addr_reg;
                        state_reg <= S_FETCH;
                    end
                    S_JPOS: begin
                        if (apos) pc_reg <= addr_reg;
                        state_reg <= S_FETCH;
                    end
                    S_HALT: begin
                        state_reg <= S_HALT;
                    end
                    default: begin
                        state_reg <= S_START;
                    end
                endcase
            end
        end
    end

    assign bus.nout     = a_reg;
    assign bus.out_stb  = out_stb_reg;
    assign bus.wait_in  = (state_reg == S_INPUT);
    assign bus.halt     = (state_reg == S_HALT);
    assign bus.ovf      = ovf_reg;
    assign bus.ir_op    = op_reg;
    assign bus.pc_out   = pc_reg;
    assign bus.state_no = state_reg;
endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench: directed programs plus random programs run in lockstep against an
// instruction-level model of the machine; a second instance exercises CLK_DIV=4.
module tb_acc_cpu_core;
    import acc_cpu_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic rst4_n;
    always #5 clk = ~clk;

    acc_cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    acc_cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus4 ();

    acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .CLK_DIV(1)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .CLK_DIV(4)) dut4 (
        .clock (clk),
        .reset (rst4_n),
        .bus   (bus4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Instruction-level model of the architecture.
    logic [7:0] img   [DEPTH];
    logic [7:0] mem_m [DEPTH];
    logic [7:0] a_m;
    logic [4:0] pc_m;
    logic       ovf_m;
    bit         halted_m;
    logic [7:0] cur_nin;
    int         wraps;

    function automatic void model_reset();
        a_m = 8'h00; pc_m = 5'd0; ovf_m = 1'b0; halted_m = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] nin_v);
        logic [7:0] w;
        logic [2:0] op;
        logic [4:0] ad;
        logic [7:0] m;
        int         s;
        w  = mem_m[pc_m];
        op = w[7:5];
        ad = w[4:0];
        m  = mem_m[ad];
        pc_m = pc_m + 5'd1;
        case (op)
            OP_LOAD:  a_m = m;
            OP_STORE: mem_m[ad] = a_m;
            OP_ADD: begin
                s = int'($signed(a_m)) + int'($signed(m));
                a_m = s[7:0]; ovf_m = (s > 127) || (s < -128);
            end
            OP_SUB: begin
                s = int'($signed(a_m)) - int'($signed(m));
                a_m = s[7:0]; ovf_m = (s > 127) || (s < -128);
            end
            OP_INPUT: a_m = nin_v;
            OP_JZ:    if (a_m == 8'h00) pc_m = ad;
            OP_JPOS:  if ($signed(a_m) > 0) pc_m = ad;
            default:  halted_m = 1'b1;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.run = 1'b0; bus.enter = 1'b0; bus.prog_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_img();
        for (int i = 0; i < DEPTH; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = 5'(i);
            bus.prog_data = img[i];
            mem_m[i]      = img[i];
            @(negedge clk);
        end
        bus.prog_we = 1'b0;
        model_reset();
    endtask

    task automatic start_run(input string name);
        bus.nin = cur_nin;
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        check({name, ".start"}, bus.state_no, S_FETCH);
    endtask

    task automatic step_instrs(input string name, input int max_instr);
        logic [2:0] op;
        logic [4:0] prev_pc;
        int         cnt;
        int         cyc;
        for (int k = 0; k < max_instr && !halted_m; k++) begin
            op      = mem_m[pc_m][7:5];
            prev_pc = pc_m;
            if (op == OP_HALT) begin
                repeat (2) @(negedge clk);
                model_step(cur_nin);
                check({name, ".halt"}, bus.halt, 1);
                check({name, ".hstate"}, bus.state_no, S_HALT);
                check({name, ".hpc"}, bus.pc_out, pc_m);
            end else if (op == OP_INPUT) begin
                repeat (2) @(negedge clk);
                check({name, ".wait"}, bus.wait_in, 1);
                cnt = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (bus.wait_in) cnt++;
                end
                check({name, ".wait_held"}, cnt, 100);
                bus.enter = 1'b1;
                @(negedge clk);
                bus.enter = 1'b0;
                cyc = 0;
                while (bus.state_no != S_FETCH && cyc < 12) begin
                    @(negedge clk);
                    cyc++;
                end
                model_step(cur_nin);
                check({name, ".in_state"}, bus.state_no, S_FETCH);
                check({name, ".in_a"}, bus.nout, a_m);
                check({name, ".in_stb"}, bus.out_stb, 1);
            end else begin
                repeat (3) @(negedge clk);
                model_step(cur_nin);
                check({name, ".a"}, bus.nout, a_m);
                check({name, ".pc"}, bus.pc_out, pc_m);
                check({name, ".ovf"}, bus.ovf, ovf_m);
                check({name, ".state"}, bus.state_no, S_FETCH);
                check({name, ".ir"}, bus.ir_op, op);
                check({name, ".stb"}, bus.out_stb,
                      (op == OP_LOAD || op == OP_ADD || op == OP_SUB) ? 1 : 0);
            end
            if (prev_pc == 5'd31 && bus.pc_out == 5'd0) wraps++;
        end
    endtask

    task automatic finish_prog(input string name);
        int diffs;
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dut.mem[i] !== mem_m[i]) diffs++;
        end
        check({name, ".mem"}, diffs, 0);
        $display("prog %-10s A=0x%02h PC=%0d ovf=%0b halt=%0b", name, bus.nout, bus.pc_out,
                 bus.ovf, bus.halt);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".nout"}, bus.nout, 0);
        check({name, ".pc"}, bus.pc_out, 0);
        check({name, ".state"}, bus.state_no, S_START);
        check({name, ".ovf"}, bus.ovf, 0);
        check({name, ".stb"}, bus.out_stb, 0);
        check({name, ".ir"}, bus.ir_op, 0);
        check({name, ".halt"}, bus.halt, 0);
        check({name, ".wait"}, bus.wait_in, 0);
    endtask

    task automatic clear_img();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nchg;
        int chg_at [3];
        logic [3:0] prev_state;
        cur_nin = 8'h00;
        wraps = 0;
        rst_n = 1'b1; rst4_n = 1'b1;
        bus.run = 0; bus.enter = 0; bus.nin = 0; bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
        bus4.run = 0; bus4.enter = 0; bus4.nin = 0; bus4.prog_we = 0; bus4.prog_addr = 0; bus4.prog_data = 0;
        #2;
        rst_n = 1'b0; rst4_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        rst_n = 1'b1;

        // Worked example: 3 + 4 stored to M7.
        clear_img();
        img[0] = 8'h05; img[1] = 8'h46; img[2] = 8'h27; img[3] = 8'hE0; img[5] = 8'd3; img[6] = 8'd4;
        do_reset(); load_img();
        start_run("sum"); step_instrs("sum", 10); finish_prog("sum");
        check("sum.m7", dut.mem[7], 7);
        check("sum.nout", bus.nout, 7);
        check("sum.halt", bus.halt, 1);

        // Signed overflow on SUB, cleared by a following ADD of zero.
        clear_img();
        img[0] = 8'h0A; img[1] = 8'h6B; img[2] = 8'h4C; img[3] = 8'hE0;
        img[10] = 8'h80; img[11] = 8'h01; img[12] = 8'h00;
        do_reset(); load_img();
        start_run("ovf"); step_instrs("ovf", 2);
        check("ovf.sub_a", bus.nout, 8'h7F);
        check("ovf.sub_ovf", bus.ovf, 1);
        step_instrs("ovf", 10); finish_prog("ovf");
        check("ovf.add_ovf", bus.ovf, 0);

        // INPUT: a press during START must be forgotten; the real press loads nin.
        clear_img();
        img[0] = 8'h80; img[1] = 8'hE0;
        do_reset(); load_img();
        bus.enter = 1'b1; @(negedge clk); bus.enter = 1'b0;
        repeat (4) @(negedge clk);
        cur_nin = 8'h2A;
        start_run("input"); step_instrs("input", 5); finish_prog("input");
        check("input.a", bus.nout, 8'h2A);

        // Countdown loop whose body runs off the top of memory and wraps to 0.
        clear_img();
        img[0] = 8'h14; img[1] = 8'hA3; img[2] = 8'hDA; img[3] = 8'hE0;
        img[26] = 8'h75; img[27] = 8'h34; img[28] = 8'h16; img[29] = 8'h55; img[30] = 8'h36;
        img[31] = 8'h14; img[20] = 8'd3; img[21] = 8'd1; img[22] = 8'd0;
        do_reset(); load_img();
        wraps = 0;
        start_run("loop"); step_instrs("loop", 40); finish_prog("loop");
        check("loop.iters", dut.mem[22], 3);
        check("loop.count", dut.mem[20], 0);
        check("loop.wraps", wraps, 3);
        check("loop.halt", bus.halt, 1);

        // Reset in the middle of ADD, then again from HALT.
        clear_img();
        img[0] = 8'h05; img[1] = 8'h46; img[2] = 8'hE0; img[5] = 8'h7F; img[6] = 8'h01;
        do_reset(); load_img();
        bus.run = 1'b1;
        cyc = 0;
        while (bus.state_no != S_ADD && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        bus.run = 1'b0;
        check("rstadd.reached", bus.state_no, S_ADD);
        rst_n = 1'b0; #1;
        check_reset_outputs("rstadd");
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        start_run("rerun"); step_instrs("rerun", 10); finish_prog("rerun");
        check("rerun.a", bus.nout, 8'h80);
        check("rerun.ovf", bus.ovf, 1);
        rst_n = 1'b0; #1;
        check_reset_outputs("rsthalt");
        @(negedge clk); rst_n = 1'b1;

        // Random programs in lockstep with the model.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
            cur_nin = 8'($urandom);
            do_reset(); load_img();
            start_run($sformatf("rand%0d", p));
            step_instrs($sformatf("rand%0d", p), 40);
            finish_prog($sformatf("rand%0d", p));
        end

        // CLK_DIV=4 instance: state moves every 4th clock, short press kept, prog_we gated.
        @(negedge clk); rst4_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus4.prog_we = 1'b1; bus4.prog_addr = 5'(i);
            bus4.prog_data = (i == 0) ? 8'h80 : (i == 1) ? 8'hE0 : (i == 15) ? 8'h3C : 8'h00;
            @(negedge clk);
        end
        bus4.prog_we = 1'b0;
        bus4.prog_addr = 5'd15; bus4.prog_data = 8'h55;
        bus4.run = 1'b1;
        nchg = 0;
        prev_state = bus4.state_no;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus4.state_no != prev_state) begin
                if (nchg < 3) chg_at[nchg] = c;
                nchg++;
                bus4.run = 1'b0;
            end
            prev_state   = bus4.state_no;
            bus4.prog_we = (bus4.state_no == S_FETCH);
        end
        bus4.prog_we = 1'b0;
        check("div4.changes", nchg, 3);
        check("div4.gap1", chg_at[1] - chg_at[0], 4);
        check("div4.gap2", chg_at[2] - chg_at[1], 4);
        check("div4.state", bus4.state_no, S_INPUT);
        check("div4.fetch_we", dut4.mem[15], 8'h3C);
        bus4.nin = 8'h5A;
        bus4.enter = 1'b1; @(negedge clk); bus4.enter = 1'b0;
        cyc = 0;
        while (bus4.state_no != S_FETCH && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("div4.in_state", bus4.state_no, S_FETCH);
        check("div4.in_a", bus4.nout, 8'h5A);
        check("div4.in_stb", bus4.out_stb, 1);
        cyc = 0;
        while (!bus4.halt && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("div4.halt", bus4.halt, 1);
        bus4.prog_we = 1'b1; @(negedge clk); bus4.prog_we = 1'b0;
        check("div4.halt_we", dut4.mem[15], 8'h55);
        $display("prog %-10s A=0x%02h halt=%0b", "div4", bus4.nout, bus4.halt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
